rice_core_env: RTL and testbench
================================

RICE_CORE_ENV -- requirements
Module: rice_core_env

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning the register and PC width; only 32 is supported.
REQ-002 SHALL have port i_clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port i_rst  input  1  reset; asynchronous, active-high.
REQ-004 SHALL have port env_if  interface  rice_core_env_if.env modport  drives privilege_level, trap_pc and return_pc; samples exception, mret, pc and inst.
REQ-005 SHALL have port i_csr_valid  input  1  CSR access strobe from the execute stage.
REQ-006 SHALL have port i_csr_op  input  2  CSR operation: 01 write, 10 set, 11 clear, 00 read-only.
REQ-007 SHALL have port i_csr_addr  input  12  CSR address.
REQ-008 SHALL have port i_csr_wdata  input  XLEN  write, set or clear operand.
REQ-009 SHALL have port o_csr_rdata  output  XLEN  old CSR value, combinational from the address.
REQ-010 SHALL have port o_csr_error  output  1  high in the same cycle when i_csr_valid is high and the address is unimplemented.

Function
REQ-011 SHALL implement these CSRs: mstatus 0x300 (MIE, MPIE, MPP), mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342 and mtval 0x343; every other bit reads 0.
REQ-012 SHALL drive env_if.trap_pc from the mtvec register as {base, 2'b00}; mtvec[1:0] is hardwired to 0 (direct mode only).
REQ-013 SHALL drive env_if.return_pc from mepc; mepc[1:0] is hardwired to 0.
REQ-014 SHALL drive env_if.privilege_level from a registered 2-bit level.
REQ-015 SHALL act on an exception when env_if.exception.valid is 1, updating the following at the next edge:
- mepc <= pc
- mcause <= {1'b0, exception.code}
- mtval <= inst when the code is 2 (illegal instruction), otherwise 0
- MPIE <= MIE, then MIE <= 0
- MPP <= privilege_level
- privilege_level <= M
REQ-016 SHALL act on env_if.mret = 1 by updating the following at the next edge:
- privilege_level <= MPP
- MIE <= MPIE, then MPIE <= 1
- MPP <= least-privileged supported level
REQ-017 SHALL give an exception priority over a simultaneous mret; the mret is ignored.
REQ-018 SHALL apply a CSR write, set or clear one cycle after i_csr_valid, computed as write = wdata, set = old | wdata, clear = old & ~wdata.
REQ-019 SHALL perform no write for i_csr_op = 00, for an unimplemented address, or in a cycle with a simultaneous exception.
REQ-020 SHALL give a CSR write priority over a simultaneous mret for mstatus fields; the mret still updates privilege_level.
REQ-021 SHALL make a CSR write to mtvec or mepc visible on trap_pc or return_pc in the cycle after the write (1-cycle latency).
REQ-022 SHALL return the pre-update value on o_csr_rdata in the access cycle (read-before-write).

Reset
REQ-023 SHALL reset asynchronously on i_rst = 1 to: privilege_level M; mstatus MIE 0, MPIE 0, MPP M; mtvec 0, mepc 0, mcause 0, mtval 0, mscratch 0.
REQ-024 SHALL drop any exception, mret or CSR access that coincides with reset, leaving no trace after release.

Configuration
REQ-025 SHALL, with RICE_CORE_USER_MODE_EN defined:
- make MPP writable between M (11) and U (00)
- coerce writes of 01 or 10 to U
- set MPP to U after mret
REQ-026 SHALL, without RICE_CORE_USER_MODE_EN, hardwire MPP to M, ignore MPP writes, and keep privilege_level at M permanently.

Structure
REQ-027 SHALL take the CSR address constants, the mstatus field struct and the privilege-level encodings from the shared package rice_core_pkg.
REQ-028 SHALL put CSR storage, address decode and read/write arithmetic in one sub-module, rice_core_env_csr; trap and mret sequencing stay in rice_core_env.

Verification
REQ-029 SHALL cover trap entry:
- stimulus: after reset, write mtvec 0x0000_1001, then exception code 2 with pc 0x0000_0100 and inst 0xFFFF_FFFF
- response: trap_pc 0x0000_1000; next cycle mepc 0x100, mcause 2, mtval 0xFFFF_FFFF, MIE 0
REQ-030 SHALL cover mret with user mode enabled:
- stimulus: set MIE, write MPP = 00 and mepc 0x200, then mret
- response: return_pc 0x200; next cycle privilege_level U, MIE = old MPIE, MPIE 1
REQ-031 SHALL cover simultaneous events: exception and mret in the same cycle -> only the trap updates occur.
REQ-032 SHALL cover CSR set and clear: write mscratch 0xF0F0_F0F0, set 0x0F0F_0000, then clear 0xFFFF_0000 -> reads 0xF0F0_F0F0, then 0xFFFF_F0F0, then 0x0000_F0F0.
REQ-033 SHALL cover an unimplemented address: access 0x7C0 -> o_csr_error 1, o_csr_rdata 0, no state change.
REQ-034 SHALL cover reset mid-operation: assert i_rst in the same cycle as an exception -> all outputs at reset values and mepc 0.

Source files
------------

// File: rtl/rice_core_pkg.sv
// rice_core_pkg: shared machine-mode CSR definitions.
//   - CSR address constants, privilege encodings, mstatus field struct,
//     exception request struct and small helpers.
//   - RICE_CORE_USER_MODE_EN: when defined, U-mode exists and MPP may hold U;
//     otherwise MPP is hardwired to M.
package rice_core_pkg;
  localparam int RICE_XLEN = 32;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;

  localparam logic [1:0] PRIV_U = 2'b00;
  localparam logic [1:0] PRIV_S = 2'b01;
  localparam logic [1:0] PRIV_M = 2'b11;

`ifdef RICE_CORE_USER_MODE_EN
  localparam logic [1:0] PRIV_LOWEST = PRIV_U;
`else
  localparam logic [1:0] PRIV_LOWEST = PRIV_M;
`endif

  typedef enum logic [1:0] {
    CSR_OP_READ  = 2'b00,
    CSR_OP_WRITE = 2'b01,
    CSR_OP_SET   = 2'b10,
    CSR_OP_CLEAR = 2'b11
  } csr_op_e;

  typedef struct packed {
    logic [1:0] mpp;
    logic       mpie;
    logic       mie;
  } mstatus_t;

  typedef struct packed {
    logic                 valid;
    logic [RICE_XLEN-2:0] code;
  } exc_t;

  localparam logic [RICE_XLEN-2:0] EXC_ILLEGAL_INST = 2;

  // Legalize a value headed for MPP.
  function automatic logic [1:0] mpp_legal(logic [1:0] p);
`ifdef RICE_CORE_USER_MODE_EN
    return (p == PRIV_M) ? PRIV_M : PRIV_U;  // S is unsupported, collapse to U
`else
    return p | PRIV_M;                       // only M exists
`endif
  endfunction

  function automatic logic [RICE_XLEN-1:0] mstatus_pack(mstatus_t s);
    logic [RICE_XLEN-1:0] r;
    r        = '0;
    r[3]     = s.mie;
    r[7]     = s.mpie;
    r[12:11] = s.mpp;
    return r;
  endfunction
endpackage

// File: rtl/rice_core_env_if.sv
// rice_core_env_if: core <-> trap environment handshake.
//   env  modport: samples exception/mret/pc/inst, drives privilege_level,
//                 trap_pc, return_pc.
//   core modport: the pipeline side, mirror image of env.
interface rice_core_env_if
  import rice_core_pkg::*;
#(parameter int XLEN = 32);
  exc_t            exception;
  logic            mret;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] inst;
  logic [1:0]      privilege_level;
  logic [XLEN-1:0] trap_pc;
  logic [XLEN-1:0] return_pc;

  modport env  (input  exception, mret, pc, inst,
                output privilege_level, trap_pc, return_pc);
  modport core (output exception, mret, pc, inst,
                input  privilege_level, trap_pc, return_pc);
endinterface

// File: rtl/rice_core_env_csr.sv
// rice_core_env_csr: machine CSR storage, decode and read/modify/write.
//   clk/rst             clock, async active-high reset
//   csr_*               execute-stage access; rdata is the old value (comb),
//                       error flags an unimplemented address while valid
//   trap_en/trap_*      trap entry update (wins over everything)
//   mret_en             mret stack pop of mstatus (loses to an mstatus write)
//   mpp, mtvec, mepc    state needed by the sequencing logic
// MPP legality follows RICE_CORE_USER_MODE_EN via rice_core_pkg.
module rice_core_env_csr
  import rice_core_pkg::*;
#(parameter int XLEN = 32) (
  input  logic            clk,
  input  logic            rst,
  input  logic            csr_valid,
  input  logic [1:0]      csr_op,
  input  logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] csr_wdata,
  output logic [XLEN-1:0] csr_rdata,
  output logic            csr_error,
  input  logic            trap_en,
  input  logic [XLEN-1:0] trap_epc,
  input  logic [XLEN-1:0] trap_cause,
  input  logic [XLEN-1:0] trap_tval,
  input  logic [1:0]      trap_priv,
  input  logic            mret_en,
  output logic [1:0]      mpp,
  output logic [XLEN-1:0] mtvec,
  output logic [XLEN-1:0] mepc
);
  // mtvec/mepc are word aligned; low two bits never hold a 1.
  localparam logic [XLEN-1:0] ALIGN4 = {{(XLEN-2){1'b1}}, 2'b00};

  mstatus_t        mstatus;
  logic [XLEN-1:0] mscratch, mcause, mtval;
  logic [XLEN-1:0] wval;
  logic            hit, we, mstatus_we;

  always_comb begin
    hit       = 1'b1;
    csr_rdata = '0;
    case (csr_addr)
      CSR_MSTATUS:  csr_rdata = mstatus_pack(mstatus);
      CSR_MTVEC:    csr_rdata = mtvec;
      CSR_MSCRATCH: csr_rdata = mscratch;
      CSR_MEPC:     csr_rdata = mepc;
      CSR_MCAUSE:   csr_rdata = mcause;
      CSR_MTVAL:    csr_rdata = mtval;
      default:      hit = 1'b0;
    endcase
  end

  always_comb begin
    case (csr_op)
      CSR_OP_WRITE: wval = csr_wdata;
      CSR_OP_SET:   wval = csr_rdata | csr_wdata;
      CSR_OP_CLEAR: wval = csr_rdata & ~csr_wdata;
      default:      wval = csr_rdata;
    endcase
  end

  assign csr_error  = csr_valid && !hit;
  assign we         = csr_valid && hit && (csr_op != CSR_OP_READ) && !trap_en;
  assign mstatus_we = we && (csr_addr == CSR_MSTATUS);
  assign mpp        = mstatus.mpp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mstatus  <= '{mpp: PRIV_M, mpie: 1'b0, mie: 1'b0};
      mtvec    <= '0;
      mscratch <= '0;
      mepc     <= '0;
      mcause   <= '0;
      mtval    <= '0;
    end else if (trap_en) begin
      mepc         <= trap_epc & ALIGN4;
      mcause       <= trap_cause;
      mtval        <= trap_tval;
      mstatus.mpie <= mstatus.mie;
      mstatus.mie  <= 1'b0;
      mstatus.mpp  <= mpp_legal(trap_priv);
    end else begin
      if (we) begin
        case (csr_addr)
          CSR_MSTATUS: begin
            mstatus.mie  <= wval[3];
            mstatus.mpie <= wval[7];
            mstatus.mpp  <= mpp_legal(wval[12:11]);
          end
          CSR_MTVEC:    mtvec    <= wval & ALIGN4;
          CSR_MSCRATCH: mscratch <= wval;
          CSR_MEPC:     mepc     <= wval & ALIGN4;
          CSR_MCAUSE:   mcause   <= wval;
          CSR_MTVAL:    mtval    <= wval;
          default: ;
        endcase
      end
      // An explicit mstatus write in the same cycle owns the fields.
      if (mret_en && !mstatus_we) begin
        mstatus.mie  <= mstatus.mpie;
        mstatus.mpie <= 1'b1;
        mstatus.mpp  <= PRIV_LOWEST;
      end
    end
  end
endmodule

// File: rtl/rice_core_env.sv
// rice_core_env: trap / mret sequencing plus machine CSR file.
//   i_clk, i_rst        clock, async active-high reset
//   env_if (env)        exception/mret/pc/inst in; privilege_level,
//                       trap_pc (mtvec), return_pc (mepc) out
//   i_csr_*             CSR access from execute; o_csr_rdata is the
//                       pre-update value, o_csr_error flags bad addresses
// Build option RICE_CORE_USER_MODE_EN enables U-mode; without it MPP and
// privilege_level stay at M.
module rice_core_env
  import rice_core_pkg::*;
#(parameter int XLEN = 32) (
  input  logic             i_clk,
  input  logic             i_rst,
  rice_core_env_if.env     env_if,
  input  logic             i_csr_valid,
  input  logic [1:0]       i_csr_op,
  input  logic [11:0]      i_csr_addr,
  input  logic [XLEN-1:0]  i_csr_wdata,
  output logic [XLEN-1:0]  o_csr_rdata,
  output logic             o_csr_error
);
  logic            trap_en, mret_en;
  logic [XLEN-1:0] tval, cause;
  logic [1:0]      priv_q, mpp;
  logic [XLEN-1:0] mtvec, mepc;

  // Exception always wins; a coincident mret is dropped.
  assign trap_en = env_if.exception.valid;
  assign mret_en = env_if.mret && !trap_en;
  assign cause   = {1'b0, env_if.exception.code};
  assign tval    = (env_if.exception.code == EXC_ILLEGAL_INST) ? env_if.inst : '0;

  // Without user mode mpp is constant M, so priv_q never leaves M.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)        priv_q <= PRIV_M;
    else if (trap_en) priv_q <= PRIV_M;
    else if (mret_en) priv_q <= mpp;
  end

  rice_core_env_csr #(.XLEN(XLEN)) u_csr (
    .clk        (i_clk),
    .rst        (i_rst),
    .csr_valid  (i_csr_valid),
    .csr_op     (i_csr_op),
    .csr_addr   (i_csr_addr),
    .csr_wdata  (i_csr_wdata),
    .csr_rdata  (o_csr_rdata),
    .csr_error  (o_csr_error),
    .trap_en    (trap_en),
    .trap_epc   (env_if.pc),
    .trap_cause (cause),
    .trap_tval  (tval),
    .trap_priv  (priv_q),
    .mret_en    (mret_en),
    .mpp        (mpp),
    .mtvec      (mtvec),
    .mepc       (mepc)
  );

  assign env_if.privilege_level = priv_q;
  assign env_if.trap_pc         = mtvec;
  assign env_if.return_pc       = mepc;
endmodule

// File: tb/tb_rice_core_env.sv
// tb_rice_core_env: directed scoreboard bench for rice_core_env.
module tb_rice_core_env;
  import rice_core_pkg::*;

`ifdef RICE_CORE_USER_MODE_EN
  localparam bit UM = 1'b1;
`else
  localparam bit UM = 1'b0;
`endif

  logic        i_clk, i_rst;
  logic        csr_valid, csr_error;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata, csr_rdata;

  rice_core_env_if #(.XLEN(32)) env_if ();

  rice_core_env #(.XLEN(32)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .env_if      (env_if.env),
    .i_csr_valid (csr_valid),
    .i_csr_op    (csr_op),
    .i_csr_addr  (csr_addr),
    .i_csr_wdata (csr_wdata),
    .o_csr_rdata (csr_rdata),
    .o_csr_error (csr_error)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct { string tag; logic [31:0] v; } exp_t;
  exp_t sb[$];
  int n_chk = 0;
  int n_fail = 0;

  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.v   = v;
    sb.push_back(e);
  endtask

  task automatic pop_cmp(input logic [31:0] obs);
    exp_t e;
    n_chk++;
    assert (sb.size() > 0) else begin
      n_fail++;
      $error("FAIL scoreboard_empty: observed %h expected an entry", obs);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      assert (obs === e.v) else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.v);
      end
    end
  endtask

  task automatic chk_sig(input string tag, input logic [31:0] exp, input logic [31:0] obs);
    push(tag, exp);
    pop_cmp(obs);
  endtask

  task automatic chk_csr(input string tag, input logic [11:0] a, input logic [31:0] exp);
    csr_addr = a;
    push(tag, exp);
    #1;
    pop_cmp(csr_rdata);
    cyc();
  endtask

  task automatic csr_do(input logic [1:0] op, input logic [11:0] a, input logic [31:0] d);
    csr_valid = 1'b1; csr_op = op; csr_addr = a; csr_wdata = d;
    cyc();
    csr_valid = 1'b0; csr_op = 2'b00; csr_wdata = '0;
  endtask

  task automatic drive_exc(input logic v, input logic [30:0] code,
                           input logic [31:0] pc, input logic [31:0] inst, input logic mret);
    env_if.exception = '{valid: v, code: code};
    env_if.pc        = pc;
    env_if.inst      = inst;
    env_if.mret      = mret;
  endtask

  task automatic chk_priv(input string tag, input logic [1:0] exp);
    chk_sig(tag, {30'd0, exp}, {30'd0, env_if.privilege_level});
  endtask

  initial begin
    i_rst = 1'b1;
    csr_valid = 1'b0; csr_op = 2'b00; csr_addr = '0; csr_wdata = '0;
    drive_exc(1'b0, '0, '0, '0, 1'b0);
    repeat (2) cyc();
    i_rst = 1'b0;
    cyc();

    // reset state
    chk_priv("rst_priv", PRIV_M);
    chk_sig("rst_trap_pc", 32'h0, env_if.trap_pc);
    chk_sig("rst_return_pc", 32'h0, env_if.return_pc);
    chk_csr("rst_mstatus", CSR_MSTATUS, 32'h0000_1800);
    chk_csr("rst_mcause", CSR_MCAUSE, 32'h0);
    chk_csr("rst_mscratch", CSR_MSCRATCH, 32'h0);

    // trap entry, illegal instruction
    csr_do(CSR_OP_WRITE, CSR_MTVEC, 32'h0000_1001);
    chk_sig("trap_pc_after_write", 32'h0000_1000, env_if.trap_pc);
    drive_exc(1'b1, 31'd2, 32'h0000_0100, 32'hFFFF_FFFF, 1'b0);
    cyc();
    drive_exc(1'b0, '0, '0, '0, 1'b0);
    chk_csr("trap_mepc", CSR_MEPC, 32'h0000_0100);
    chk_csr("trap_mcause", CSR_MCAUSE, 32'h2);
    chk_csr("trap_mtval", CSR_MTVAL, 32'hFFFF_FFFF);
    chk_csr("trap_mstatus", CSR_MSTATUS, 32'h0000_1800);
    chk_priv("trap_priv", PRIV_M);

    // trap with MIE set and a non-illegal code: mtval cleared, MIE stacked
    csr_do(CSR_OP_SET, CSR_MSTATUS, 32'h8);
    chk_csr("set_mie", CSR_MSTATUS, 32'h0000_1808);
    drive_exc(1'b1, 31'd5, 32'h0000_0104, 32'h0000_1234, 1'b0);
    cyc();
    drive_exc(1'b0, '0, '0, '0, 1'b0);
    chk_csr("trap2_mcause", CSR_MCAUSE, 32'h5);
    chk_csr("trap2_mtval", CSR_MTVAL, 32'h0);
    chk_csr("trap2_mstatus", CSR_MSTATUS, 32'h0000_1880);
    chk_sig("trap2_return_pc", 32'h0000_0104, env_if.return_pc);

    // MPP = 01 is not a supported level
    csr_do(CSR_OP_WRITE, CSR_MSTATUS, 32'h0000_0888);
    chk_csr("mpp_coerce", CSR_MSTATUS, UM ? 32'h0000_0088 : 32'h0000_1888);

    // mret: MIE=1, MPIE=0, MPP=U
    csr_do(CSR_OP_WRITE, CSR_MSTATUS, 32'h0000_0008);
    chk_csr("pre_mret_mstatus", CSR_MSTATUS, UM ? 32'h0000_0008 : 32'h0000_1808);
    csr_do(CSR_OP_WRITE, CSR_MEPC, 32'h0000_0203);
    chk_sig("mepc_align", 32'h0000_0200, env_if.return_pc);
    csr_do(CSR_OP_WRITE, CSR_MEPC, 32'h0000_0200);
    chk_sig("return_pc", 32'h0000_0200, env_if.return_pc);
    drive_exc(1'b0, '0, '0, '0, 1'b1);
    cyc();
    drive_exc(1'b0, '0, '0, '0, 1'b0);
    chk_priv("mret_priv", UM ? PRIV_U : PRIV_M);
    chk_csr("mret_mstatus", CSR_MSTATUS, UM ? 32'h0000_0080 : 32'h0000_1880);

    // trap taken from the current level records it in MPP
    drive_exc(1'b1, 31'd8, 32'h0000_0204, 32'h0, 1'b0);
    cyc();
    drive_exc(1'b0, '0, '0, '0, 1'b0);
    chk_csr("trap3_mstatus", CSR_MSTATUS, UM ? 32'h0000_0000 : 32'h0000_1800);
    chk_priv("trap3_priv", PRIV_M);

    // CSR write to mstatus beats mret, privilege still follows old MPP
    csr_do(CSR_OP_WRITE, CSR_MSTATUS, 32'h0000_0080);
    csr_valid = 1'b1; csr_op = CSR_OP_WRITE; csr_addr = CSR_MSTATUS; csr_wdata = 32'h0000_1800;
    drive_exc(1'b0, '0, '0, '0, 1'b1);
    cyc();
    csr_valid = 1'b0; csr_op = 2'b00;
    drive_exc(1'b0, '0, '0, '0, 1'b0);
    chk_csr("wr_vs_mret_mstatus", CSR_MSTATUS, 32'h0000_1800);
    chk_priv("wr_vs_mret_priv", UM ? PRIV_U : PRIV_M);

    // exception + mret + CSR write in one cycle: only the trap lands
    csr_do(CSR_OP_WRITE, CSR_MSTATUS, 32'h0000_1888);
    csr_valid = 1'b1; csr_op = CSR_OP_WRITE; csr_addr = CSR_MSCRATCH; csr_wdata = 32'h1234_5678;
    drive_exc(1'b1, 31'd3, 32'h0000_0300, 32'h0, 1'b1);
    cyc();
    csr_valid = 1'b0; csr_op = 2'b00;
    drive_exc(1'b0, '0, '0, '0, 1'b0);
    chk_csr("simul_mstatus", CSR_MSTATUS, UM ? 32'h0000_0080 : 32'h0000_1880);
    chk_priv("simul_priv", PRIV_M);
    chk_csr("simul_mepc", CSR_MEPC, 32'h0000_0300);
    chk_csr("simul_mscratch", CSR_MSCRATCH, 32'h0);

    // set / clear with read-before-write
    csr_do(CSR_OP_WRITE, CSR_MSCRATCH, 32'hF0F0_F0F0);
    chk_csr("scratch_wr", CSR_MSCRATCH, 32'hF0F0_F0F0);
    csr_valid = 1'b1; csr_op = CSR_OP_SET; csr_addr = CSR_MSCRATCH; csr_wdata = 32'h0F0F_0000;
    #1;
    chk_sig("rbw_old_value", 32'hF0F0_F0F0, csr_rdata);
    cyc();
    csr_valid = 1'b0; csr_op = 2'b00;
    chk_csr("scratch_set", CSR_MSCRATCH, 32'hFFFF_F0F0);
    csr_do(CSR_OP_CLEAR, CSR_MSCRATCH, 32'hFFFF_0000);
    chk_csr("scratch_clr", CSR_MSCRATCH, 32'h0000_F0F0);

    // unimplemented address
    csr_valid = 1'b1; csr_op = CSR_OP_WRITE; csr_addr = 12'h7C0; csr_wdata = 32'hFFFF_FFFF;
    #1;
    chk_sig("bad_addr_error", 32'h1, {31'd0, csr_error});
    chk_sig("bad_addr_rdata", 32'h0, csr_rdata);
    cyc();
    csr_valid = 1'b0; csr_op = 2'b00;
    #1;
    chk_sig("bad_addr_idle_error", 32'h0, {31'd0, csr_error});
    chk_csr("bad_addr_scratch", CSR_MSCRATCH, 32'h0000_F0F0);
    chk_csr("bad_addr_mtvec", CSR_MTVEC, 32'h0000_1000);

    // reset coinciding with an exception and an mret
    drive_exc(1'b1, 31'd2, 32'h0000_0400, 32'h0000_0ABC, 1'b1);
    i_rst = 1'b1;
    #1;
    chk_sig("rst_async_trap_pc", 32'h0, env_if.trap_pc);
    cyc();
    drive_exc(1'b0, '0, '0, '0, 1'b0);
    i_rst = 1'b0;
    cyc();
    chk_sig("rstmid_return_pc", 32'h0, env_if.return_pc);
    chk_priv("rstmid_priv", PRIV_M);
    chk_csr("rstmid_mepc", CSR_MEPC, 32'h0);
    chk_csr("rstmid_mcause", CSR_MCAUSE, 32'h0);
    chk_csr("rstmid_mtval", CSR_MTVAL, 32'h0);
    chk_csr("rstmid_mstatus", CSR_MSTATUS, 32'h0000_1800);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
